// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the push-button input path: FSM state encodings and
// default cycle counts for the 25 MHz system clock.
package button_event_decoder_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_LONG    = 2'd2
  } btn_state_t;

  // 10 ms debounce window and 800 ms long-press threshold at 25 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_LONG_CYCLES     = 20000000;

endpackage

// File: rtl/button_event_decoder_debounce_sync.sv
// Two-flop synchroniser plus debounce counter for a raw mechanical input.
// Produces the debounced level and one-cycle rise/fall strobes on the flip edge.
module debounce_sync
  import button_event_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic rise,
  output logic fall
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          sync_p;
  logic [DW-1:0] deb_cnt;

  // Synchroniser resets to the idle pin level so no phantom press follows reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= ACTIVE_LOW;
      sync_2 <= ACTIVE_LOW;
    end else begin
      sync_1 <= btn_in;
      sync_2 <= sync_1;
    end
  end

  assign sync_p = sync_2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_p == btn_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_level <= sync_p;
        deb_cnt   <= '0;
        rise      <= sync_p;
        fall      <= ~sync_p;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Push-button front end: debounced level, press/release strobes and a
// short/long press classifier driven by a hold-time counter.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_25m,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic held_long
);

  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  btn_state_t    state;
  btn_state_t    state_next;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic          rise;
  logic          fall;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_debounce (
    .clk      (clk_25m),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .rise     (rise),
    .fall     (fall)
  );

  assign press_pulse   = rise;
  assign release_pulse = fall;
  assign hold_done     = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      state <= BTN_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A release landing on the threshold cycle wins, so the press counts as short
  always_comb begin
    state_next  = state;
    short_press = 1'b0;
    long_press  = 1'b0;
    case (state)
      BTN_IDLE: begin
        if (rise) begin
          state_next = BTN_PRESSED;
        end
      end
      BTN_PRESSED: begin
        if (fall) begin
          short_press = 1'b1;
          state_next  = BTN_IDLE;
        end else if (hold_done) begin
          long_press = 1'b1;
          state_next = BTN_LONG;
        end
      end
      BTN_LONG: begin
        if (fall) begin
          state_next = BTN_IDLE;
        end
      end
      default: begin
        state_next = BTN_IDLE;
      end
    endcase
  end

  // Counter saturates at the threshold so it never wraps during a long hold
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if ((state == BTN_IDLE) && rise) begin
      hold_cnt <= '0;
    end else if ((state == BTN_PRESSED) && !hold_done) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      held_long <= 1'b0;
    end else if (long_press) begin
      held_long <= 1'b1;
    end else if ((state == BTN_LONG) && fall) begin
      held_long <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with short debounce/long windows.
// A window-based reference model is compared against the DUT every cycle.
module tb_button_event_decoder;

  localparam int DEB  = 8;
  localparam int LONG = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b1;
  logic btn_level, press_pulse, release_pulse, short_press, long_press, held_long;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  button_event_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk_25m      (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .held_long    (held_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference model: the level flips once the last DEB synchronised samples
  // (taken since the previous flip) all disagree with it; press age decides short/long.
  bit sq[$];
  bit m_level, pin_prev;
  int n, press_edge, long_edge;
  bit e_level, e_press, e_rel, e_short, e_long, e_held;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sq.delete();
      m_level = 0; pin_prev = 0; n = 0; press_edge = 0; long_edge = -1;
      e_level = 0; e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_held = 0;
    end else begin
      bit sync_now, flip;
      n++;
      sync_now = pin_prev;
      pin_prev = ~btn_in;
      flip = (sq.size() >= DEB);
      for (int i = 0; i < sq.size(); i++)
        if (sq[i] == m_level) flip = 0;
      e_press = 0; e_rel = 0; e_short = 0; e_long = 0;
      if (flip) begin
        m_level = ~m_level;
        sq.delete();
        if (m_level) begin
          e_press = 1;
          press_edge = n;
        end else begin
          e_rel = 1;
          e_short = ((n - press_edge) <= LONG);
        end
      end else if (m_level && (n - press_edge == LONG)) begin
        e_long = 1;
        long_edge = n;
      end
      e_held = (long_edge >= 0) && (n > long_edge);
      if (flip && !m_level) long_edge = -1;
      e_level = m_level;
      sq.push_back(sync_now);
      if (sq.size() > DEB) void'(sq.pop_front());
    end
  end

  task automatic cmpBit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cmpBit("btn_level", btn_level, e_level);
    cmpBit("press_pulse", press_pulse, e_press);
    cmpBit("release_pulse", release_pulse, e_rel);
    cmpBit("short_press", short_press, e_short);
    cmpBit("long_press", long_press, e_long);
    cmpBit("held_long", held_long, e_held);
  end

  // Event log of observed DUT strobes, used by the literal checks
  int press_cnt, rel_cnt, short_cnt, long_cnt, held_cnt, act_cnt;
  int last_press, last_rel, last_short, last_long;

  always @(negedge clk) begin
    if (press_pulse === 1'b1) begin press_cnt++; last_press = cyc; end
    if (release_pulse === 1'b1) begin rel_cnt++; last_rel = cyc; end
    if (short_press === 1'b1) begin short_cnt++; last_short = cyc; end
    if (long_press === 1'b1) begin long_cnt++; last_long = cyc; end
    if (held_long === 1'b1) held_cnt++;
    if ({btn_level, press_pulse, release_pulse, short_press, long_press, held_long} !== 6'b0)
      act_cnt++;
  end

  task automatic clearLog();
    press_cnt = 0; rel_cnt = 0; short_cnt = 0; long_cnt = 0; held_cnt = 0; act_cnt = 0;
    last_press = -1; last_rel = -1; last_short = -1; last_long = -1;
  endtask

  task automatic applyStimulus(input logic value, input int cycles);
    btn_in = value;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int c0, c1;
    clearLog();
    btn_in = 1'b1;
    #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    $display("[TB] test 1: idle after reset");
    clearLog();
    applyStimulus(1'b1, 100);
    checkOutput("t1_quiet", act_cnt, 0);

    $display("[TB] test 2: 7-cycle glitch rejected");
    clearLog();
    applyStimulus(1'b0, 7);
    applyStimulus(1'b1, 30);
    checkOutput("t2_press_cnt", press_cnt, 0);
    checkOutput("t2_active_cnt", act_cnt, 0);

    $display("[TB] test 3: 20-cycle short press");
    clearLog();
    c0 = cyc;
    applyStimulus(1'b0, 20);
    c1 = cyc;
    applyStimulus(1'b1, 30);
    checkOutput("t3_press_lat", last_press - c0, 10);
    checkOutput("t3_release_lat", last_rel - c1, 10);
    checkOutput("t3_short_lat", last_short - c1, 10);
    checkOutput("t3_short_cnt", short_cnt, 1);
    checkOutput("t3_long_cnt", long_cnt, 0);

    $display("[TB] test 4: 100-cycle long press");
    clearLog();
    c0 = cyc;
    applyStimulus(1'b0, 100);
    c1 = cyc;
    applyStimulus(1'b1, 30);
    checkOutput("t4_press_lat", last_press - c0, 10);
    checkOutput("t4_long_delay", last_long - last_press, 40);
    checkOutput("t4_long_cnt", long_cnt, 1);
    checkOutput("t4_short_cnt", short_cnt, 0);
    checkOutput("t4_held_cycles", held_cnt, 60);
    checkOutput("t4_release_lat", last_rel - c1, 10);

    $display("[TB] test 5: release on the threshold cycle is short");
    clearLog();
    applyStimulus(1'b0, 40);
    applyStimulus(1'b1, 30);
    checkOutput("t5_short_cnt", short_cnt, 1);
    checkOutput("t5_long_cnt", long_cnt, 0);
    checkOutput("t5_short_age", last_short - last_press, 40);

    $display("[TB] test 6: one cycle past the threshold is long");
    clearLog();
    applyStimulus(1'b0, 41);
    applyStimulus(1'b1, 30);
    checkOutput("t6_long_cnt", long_cnt, 1);
    checkOutput("t6_short_cnt", short_cnt, 0);
    checkOutput("t6_held_cycles", held_cnt, 1);

    $display("[TB] test 7: bouncing contact");
    clearLog();
    for (int i = 0; i < 10; i++) applyStimulus(logic'(i % 2), 3);
    c0 = cyc;
    applyStimulus(1'b0, 20);
    checkOutput("t7_press_cnt", press_cnt, 1);
    checkOutput("t7_press_lat", last_press - c0, 10);
    applyStimulus(1'b1, 30);

    $display("[TB] test 8: reset while held long");
    clearLog();
    applyStimulus(1'b0, 60);
    checkOutput("t8_held_before", int'(held_long), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t8_rst_level", int'(btn_level), 0);
    checkOutput("t8_rst_held", int'(held_long), 0);
    checkOutput("t8_rst_long", int'(long_press), 0);
    checkOutput("t8_rst_release", int'(release_pulse), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clearLog();
    c0 = cyc;
    applyStimulus(1'b0, 30);
    checkOutput("t8_repress_cnt", press_cnt, 1);
    checkOutput("t8_repress_lat", last_press - c0, 10);
    checkOutput("t8_no_release", rel_cnt, 0);
    applyStimulus(1'b1, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
